// File: rtl/uart_tx_pacer.sv
// Paces TX FIFO frames into the serializer with guard gap, byte count and idle-line pulse.
// Optional frame watchdog enabled by defining UART_TX_WDT_EN.
//
//  state   | meaning
//  S_IDLE  | waiting for tx_en_i with data in the FIFO; launches a frame
//  S_BUSY  | frame in flight, waiting for tx_done_i
//  S_GUARD | inter-frame gap of guard_bits bit times
//  S_DRAIN | FIFO empty after a frame; counts IDLE_BITS bit times before tx_idle_o
module uart_tx_pacer #(
  parameter int unsigned IDLE_BITS = 10,
  parameter int unsigned WDT_BITS  = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] baud,
  input  logic [3:0]  guard_bits,
  input  logic        tx_en_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_o,
  output logic        tx_start_o,
  input  logic        tx_done_i,
  input  logic        byte_clr_i,
  output logic [15:0] byte_count_o,
  output logic        tx_idle_o,
  output logic        tx_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GUARD, S_DRAIN} state_e;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_BITS - 1);
`ifdef UART_TX_WDT_EN
  localparam logic [7:0] WDT_LAST  = 8'(WDT_BITS - 1);
`endif

  state_e      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  guard_q, guard_d;
  logic [15:0] count_q, count_d;
  logic        launch_q, launch_d;
  logic        idle_q, idle_d;
  logic        err_q, err_d;

  logic [15:0] baud_eff;
  logic        bit_tick;
  logic        launch_ok;
  logic        guard_last;
  logic        idle_last;
  logic        wdt_last;

  assign baud_eff   = (baud == 16'd0) ? 16'd1 : baud;
  // >= so a baud reduced below the running count still ticks on the next compare
  assign bit_tick   = (clk_cnt_q >= (baud_eff - 16'd1));
  assign launch_ok  = tx_en_i & ~fifo_empty_i;
  assign guard_last = bit_tick && (bit_cnt_q == ({4'd0, guard_q} - 8'd1));
  assign idle_last  = bit_tick && (bit_cnt_q == IDLE_LAST);
`ifdef UART_TX_WDT_EN
  assign wdt_last   = bit_tick && (bit_cnt_q == WDT_LAST);
`else
  assign wdt_last   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 8'd0;
      guard_q   <= 4'd0;
      count_q   <= 16'd0;
      launch_q  <= 1'b0;
      idle_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      guard_q   <= guard_d;
      count_q   <= count_d;
      launch_q  <= launch_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (launch_ok) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (tx_done_i) begin
          if (guard_bits != 4'd0) state_d = S_GUARD;
          else if (!fifo_empty_i) state_d = S_IDLE;
          else                    state_d = S_DRAIN;
        end else if (wdt_last) begin
          state_d = S_IDLE;
        end
      end
      S_GUARD: begin
        if (guard_last) state_d = launch_ok ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (launch_ok || idle_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      clk_cnt_d = 16'd0;
      bit_cnt_d = 8'd0;
    end else if (bit_tick) begin
      clk_cnt_d = 16'd0;
      bit_cnt_d = bit_cnt_q + 8'd1;
    end else begin
      clk_cnt_d = clk_cnt_q + 16'd1;
      bit_cnt_d = bit_cnt_q;
    end
  end

  always_comb begin
    launch_d = (state_q == S_IDLE) && launch_ok;
    idle_d   = (state_q == S_DRAIN) && !launch_ok && idle_last;
    err_d    = (state_q == S_BUSY) && !tx_done_i && wdt_last;
    guard_d  = ((state_q == S_BUSY) && tx_done_i) ? guard_bits : guard_q;
    if (byte_clr_i)                             count_d = 16'd0;
    else if ((state_q == S_BUSY) && tx_done_i)  count_d = count_q + 16'd1;
    else                                        count_d = count_q;
  end

  assign fifo_rd_o    = launch_q;
  assign tx_start_o   = launch_q;
  assign byte_count_o = count_q;
  assign tx_idle_o    = idle_q;
  assign tx_err_o     = err_q;

endmodule

// File: tb/tb_uart_tx_pacer.sv
// Directed self-checking bench for uart_tx_pacer (watchdog cases when UART_TX_WDT_EN is defined).
module tb_uart_tx_pacer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] baud;
  logic [3:0]  guard_bits;
  logic        tx_en_i;
  logic        fifo_empty_i;
  logic        fifo_rd_o;
  logic        tx_start_o;
  logic        tx_done_i;
  logic        byte_clr_i;
  logic [15:0] byte_count_o;
  logic        tx_idle_o;
  logic        tx_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_pacer #(.IDLE_BITS(10), .WDT_BITS(12)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .baud         (baud),
    .guard_bits   (guard_bits),
    .tx_en_i      (tx_en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_o    (fifo_rd_o),
    .tx_start_o   (tx_start_o),
    .tx_done_i    (tx_done_i),
    .byte_clr_i   (byte_clr_i),
    .byte_count_o (byte_count_o),
    .tx_idle_o    (tx_idle_o),
    .tx_err_o     (tx_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Call at the negedge right after tx_start_o is seen; tx_done_i is sampled lat edges after the start edge.
  task automatic frame_done(input int lat, input logic clr);
    @(negedge clk_i);
    check("start_width", {31'd0, tx_start_o}, 32'd0);
    repeat (lat - 2) @(negedge clk_i);
    tx_done_i  = 1'b1;
    byte_clr_i = clr;
    @(negedge clk_i);
    tx_done_i  = 1'b0;
    byte_clr_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int n_idle;
    int n_start;
    int n_err;

    rst_ni = 1'b0; baud = 16'd4; guard_bits = 4'd0; tx_en_i = 1'b1;
    fifo_empty_i = 1'b1; tx_done_i = 1'b0; byte_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_start", {31'd0, tx_start_o}, 32'd0);
    check("rst_rd",    {31'd0, fifo_rd_o},  32'd0);
    check("rst_idle",  {31'd0, tx_idle_o},  32'd0);
    check("rst_err",   {31'd0, tx_err_o},   32'd0);
    check("rst_count", {16'd0, byte_count_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // back-to-back, two bytes queued
    fifo_empty_i = 1'b0;
    @(negedge clk_i);
    check("b2b_start0", {31'd0, tx_start_o}, 32'd1);
    check("b2b_rd0",    {31'd0, fifo_rd_o},  32'd1);
    frame_done(40, 1'b0);
    check("b2b_count1", {16'd0, byte_count_o}, 32'd1);
    check("b2b_gap",    {31'd0, tx_start_o}, 32'd0);
    @(negedge clk_i);
    check("b2b_start1", {31'd0, tx_start_o}, 32'd1);
    fifo_empty_i = 1'b1;
    frame_done(40, 1'b0);
    check("b2b_count2", {16'd0, byte_count_o}, 32'd2);
    repeat (39) @(negedge clk_i);
    check("drain_early", {31'd0, tx_idle_o}, 32'd0);
    @(negedge clk_i);
    check("drain_idle",  {31'd0, tx_idle_o}, 32'd1);
    @(negedge clk_i);
    check("idle_width",  {31'd0, tx_idle_o}, 32'd0);
    n_idle = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (tx_idle_o) n_idle++;
    end
    check("idle_no_repeat", n_idle, 0);

    // guard gap of 2 bits at baud 4; guard_bits changed mid-guard must not matter
    guard_bits = 4'd2; fifo_empty_i = 1'b0;
    @(negedge clk_i);
    check("guard_start", {31'd0, tx_start_o}, 32'd1);
    frame_done(10, 1'b0);
    guard_bits = 4'd5;
    repeat (8) @(negedge clk_i);
    check("guard_e8", {31'd0, tx_start_o}, 32'd0);
    @(negedge clk_i);
    check("guard_e9", {31'd0, tx_start_o}, 32'd1);
    guard_bits = 4'd0; fifo_empty_i = 1'b1;

    // drain cancelled by refill 20 cycles in
    frame_done(10, 1'b0);
    repeat (19) @(negedge clk_i);
    fifo_empty_i = 1'b0;
    @(negedge clk_i);
    check("cancel_no_start", {31'd0, tx_start_o}, 32'd0);
    check("cancel_no_idle",  {31'd0, tx_idle_o},  32'd0);
    @(negedge clk_i);
    check("cancel_start", {31'd0, tx_start_o}, 32'd1);

    // tx_en_i dropped mid-frame: guard then drain still complete
    tx_en_i = 1'b0; guard_bits = 4'd1;
    n_idle = 0;
    repeat (25) begin
      @(negedge clk_i);
      if (tx_idle_o) n_idle++;
    end
    check("cancel_idle_cnt", n_idle, 0);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("en_off_count", {16'd0, byte_count_o}, 32'd5);
    n_idle = 0; n_start = 0;
    repeat (43) begin
      @(negedge clk_i);
      if (tx_idle_o)  n_idle++;
      if (tx_start_o) n_start++;
    end
    check("en_off_early_idle", n_idle, 0);
    check("en_off_no_start",   n_start, 0);
    @(negedge clk_i);
    check("en_off_idle", {31'd0, tx_idle_o}, 32'd1);

    // byte counter wrap and clear-wins
    force dut.count_q = 16'hFFFE;
    @(negedge clk_i);
    release dut.count_q;
    guard_bits = 4'd0; tx_en_i = 1'b1;
    @(negedge clk_i);
    check("wrap_start0", {31'd0, tx_start_o}, 32'd1);
    frame_done(3, 1'b0);
    check("count_ffff", {16'd0, byte_count_o}, 32'h0000FFFF);
    @(negedge clk_i);
    frame_done(3, 1'b0);
    check("count_wrap", {16'd0, byte_count_o}, 32'd0);
    @(negedge clk_i);
    frame_done(3, 1'b0);
    check("count_one", {16'd0, byte_count_o}, 32'd1);
    @(negedge clk_i);
    frame_done(3, 1'b1);
    check("clr_with_done", {16'd0, byte_count_o}, 32'd0);

    // baud 0 behaves as 1: one guard bit lasts one cycle
    baud = 16'd0; guard_bits = 4'd1;
    @(negedge clk_i);
    check("baud0_start", {31'd0, tx_start_o}, 32'd1);
    frame_done(3, 1'b0);
    check("baud0_gap0", {31'd0, tx_start_o}, 32'd0);
    @(negedge clk_i);
    check("baud0_gap1", {31'd0, tx_start_o}, 32'd0);
    @(negedge clk_i);
    check("baud0_start2", {31'd0, tx_start_o}, 32'd1);

    // async reset while in guard
    baud = 16'd4; guard_bits = 4'd3; fifo_empty_i = 1'b1;
    frame_done(3, 1'b0);
    repeat (5) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("grst_start", {31'd0, tx_start_o}, 32'd0);
    check("grst_idle",  {31'd0, tx_idle_o},  32'd0);
    check("grst_err",   {31'd0, tx_err_o},   32'd0);
    check("grst_count", {16'd0, byte_count_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    n_idle = 0; n_start = 0;
    repeat (80) begin
      @(negedge clk_i);
      if (tx_idle_o)  n_idle++;
      if (tx_start_o) n_start++;
    end
    check("grst_no_idle",  n_idle, 0);
    check("grst_no_start", n_start, 0);

    // watchdog
    baud = 16'd2; guard_bits = 4'd0; fifo_empty_i = 1'b0;
    @(negedge clk_i);
    check("wdt_start", {31'd0, tx_start_o}, 32'd1);
    fifo_empty_i = 1'b1;
`ifdef UART_TX_WDT_EN
    repeat (23) @(negedge clk_i);
    check("wdt_early", {31'd0, tx_err_o}, 32'd0);
    @(negedge clk_i);
    check("wdt_err",   {31'd0, tx_err_o}, 32'd1);
    check("wdt_count", {16'd0, byte_count_o}, 32'd0);
    @(negedge clk_i);
    check("wdt_width", {31'd0, tx_err_o}, 32'd0);
    fifo_empty_i = 1'b0;
    @(negedge clk_i);
    check("wdt_start2", {31'd0, tx_start_o}, 32'd1);
    fifo_empty_i = 1'b1;
    repeat (23) @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("wdt_edge_err",   {31'd0, tx_err_o}, 32'd0);
    check("wdt_edge_count", {16'd0, byte_count_o}, 32'd1);
`else
    n_err = 0;
    repeat (100) begin
      @(negedge clk_i);
      if (tx_err_o) n_err++;
    end
    check("nowdt_err", n_err, 0);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("nowdt_count", {16'd0, byte_count_o}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
